// File: rtl/sim_supervisor_pkg.sv
// Shared types and constants for the simulation/bring-up supervisor.
package sim_supervisor_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_HOLD,
        ST_RUN,
        ST_DONE,
        ST_TIMEOUT
    } state_t;

    localparam logic [31:0] TOHOST_PASS       = 32'h1;
    localparam logic [3:0]  TOHOST_STRB       = 4'hF;
    localparam logic [3:0]  CONSOLE_STRB_MASK = 4'h1;

endpackage

// File: rtl/sim_supervisor_sync_fifo.sv
// Show-ahead synchronous FIFO: head entry is presented on o_data whenever o_empty is low.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

endmodule

// File: rtl/sim_supervisor.sv
// Bring-up supervisor: sequences core power-up/reset, counts run cycles, decodes tohost end-of-test.
// Console byte FIFO is built only when SIM_SUPERVISOR_CONSOLE_EN is defined.
module sim_supervisor
    import sim_supervisor_pkg::*;
#(
    parameter int          INIT_CYCLES    = 10,
    parameter int          RESET_CYCLES   = 3,
    parameter int          TIMEOUT_CYCLES = 125000,
    parameter int          CNT_W          = 32,
    parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
    parameter logic [31:0] CONSOLE_ADDR   = 32'h0000_1004,
    parameter int          CONSOLE_DEPTH  = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             store_valid,
    input  logic [31:0]      store_addr,
    input  logic [31:0]      store_data,
    input  logic [3:0]       store_strb,
    output logic             core_reset,
    output logic             init_phase,
    output logic             running,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [30:0]      exit_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic             console_valid,
    output logic [7:0]       console_data,
    input  logic             console_ready,
    output logic             console_overflow
);

    localparam logic [31:0]      INIT_END = 32'(INIT_CYCLES);
    localparam logic [31:0]      SEQ_END  = 32'(INIT_CYCLES + RESET_CYCLES);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           r_state;
    logic [31:0]      r_phase_cnt;
    logic             r_core_reset;
    logic             r_init_phase;
    logic             r_running;
    logic             r_done;
    logic             r_pass;
    logic             r_timeout;
    logic [30:0]      r_exit_code;
    logic [CNT_W-1:0] r_cycle_cnt;

    logic             w_in_run;
    logic             w_tohost_hit;
    logic             w_timeout_hit;
    logic [CNT_W-1:0] w_cnt_next;

    assign w_in_run      = (r_state == ST_RUN);
    // Even tohost values are progress writes, not terminations.
    assign w_tohost_hit  = w_in_run && store_valid && (store_addr == TOHOST_ADDR)
                           && (store_strb == TOHOST_STRB) && store_data[0];
    assign w_timeout_hit = w_in_run && (r_cycle_cnt == TO_LAST);
    assign w_cnt_next    = (r_cycle_cnt == CNT_MAX) ? r_cycle_cnt : r_cycle_cnt + CNT_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_INIT;
            r_phase_cnt  <= '0;
            r_core_reset <= 1'b1;
            r_init_phase <= 1'b1;
            r_running    <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_timeout    <= 1'b0;
            r_exit_code  <= '0;
            r_cycle_cnt  <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_phase_cnt <= r_phase_cnt + 32'd1;
                    if (r_phase_cnt == INIT_END) begin
                        r_init_phase <= 1'b0;
                        if (RESET_CYCLES == 0) begin
                            r_state      <= ST_RUN;
                            r_core_reset <= 1'b0;
                            r_running    <= 1'b1;
                        end else begin
                            r_state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    r_phase_cnt <= r_phase_cnt + 32'd1;
                    if (r_phase_cnt == SEQ_END) begin
                        r_state      <= ST_RUN;
                        r_core_reset <= 1'b0;
                        r_running    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // The terminating cycle is itself counted; tohost beats timeout.
                    r_cycle_cnt <= w_cnt_next;
                    if (w_tohost_hit) begin
                        r_state      <= ST_DONE;
                        r_done       <= 1'b1;
                        r_pass       <= (store_data == TOHOST_PASS);
                        r_exit_code  <= store_data[31:1];
                        r_core_reset <= 1'b1;
                        r_running    <= 1'b0;
                    end else if (w_timeout_hit) begin
                        r_state      <= ST_TIMEOUT;
                        r_timeout    <= 1'b1;
                        r_core_reset <= 1'b1;
                        r_running    <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign core_reset  = r_core_reset;
    assign init_phase  = r_init_phase;
    assign running     = r_running;
    assign done        = r_done;
    assign pass        = r_pass;
    assign timeout     = r_timeout;
    assign exit_code   = r_exit_code;
    assign cycle_count = r_cycle_cnt;

`ifdef SIM_SUPERVISOR_CONSOLE_EN
    logic       w_con_push;
    logic       w_con_full;
    logic       w_con_empty;
    logic [7:0] w_con_data;
    logic       r_con_overflow;

    assign w_con_push = w_in_run && store_valid && (store_addr == CONSOLE_ADDR)
                        && ((store_strb & CONSOLE_STRB_MASK) != 4'h0);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (CONSOLE_DEPTH)
    ) u_console_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_con_push),
        .i_data  (store_data[7:0]),
        .i_pop   (console_ready),
        .o_data  (w_con_data),
        .o_full  (w_con_full),
        .o_empty (w_con_empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_con_overflow <= 1'b0;
        end else if (w_con_push && w_con_full && !console_ready) begin
            r_con_overflow <= 1'b1;
        end
    end

    assign console_valid    = !w_con_empty;
    assign console_data     = w_con_data;
    assign console_overflow = r_con_overflow;
`else
    logic w_unused_console;

    assign w_unused_console = console_ready & (store_addr == CONSOLE_ADDR)
                              & (CONSOLE_DEPTH > 1) & (CONSOLE_STRB_MASK != 4'h0);
    assign console_valid    = 1'b0;
    assign console_data     = 8'h00;
    assign console_overflow = 1'b0;
`endif

endmodule

// File: doc/sim_supervisor.md
Name: sim_supervisor

Overview:
- Simulation and bring-up supervisor that sits between the processor and the top-level bench.
- Sequences the core's power-up and reset, then counts run cycles.
- Detects a tohost-style end-of-test store and reports pass, fail or timeout.
- Replaces hand-written delay/reset/finish logic in benches with a parametrised, reusable, synthesisable block.

Parameters:
INIT_CYCLES, 10, cycles after reset release spent in the memory-load window before core reset is applied
RESET_CYCLES, 3, cycles core_reset is held after the init window
TIMEOUT_CYCLES, 125000, RUN cycles before declaring timeout (10 ms at 12.5 MHz); must be >= 1
CNT_W, 32, width of cycle counter
TOHOST_ADDR, 32'h0000_1000, word address of end-of-test register
CONSOLE_ADDR, 32'h0000_1004, address of console byte register
CONSOLE_DEPTH, 16, console FIFO depth; power of 2, >= 2

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
store_valid  in  1  core data-bus store strobe, one cycle per store
store_addr  in  32  store address
store_data  in  32  store data
store_strb  in  4  byte enables
core_reset  out  1  reset to processor
init_phase  out  1  high during the memory-load window
running  out  1  core released and test in progress
done  out  1  sticky: test ended by a tohost store
pass  out  1  valid when done: 1 means tohost value was 1
timeout  out  1  sticky: TIMEOUT_CYCLES elapsed without a tohost store
exit_code  out  31  store_data[31:1] of the terminating tohost store
cycle_count  out  CNT_W  number of RUN cycles; frozen after termination
console_valid  out  1  console byte available
console_data  out  8  head-of-FIFO byte
console_ready  in  1  consumer accepts byte
console_overflow  out  1  sticky: a console byte was dropped because the FIFO was full

Behaviour:
- Clock and reset: single clock. Reset is synchronous and active-high; ports are named clock and reset.
- Reset values:
  - State = INIT, internal counter = 0.
  - core_reset = 1, init_phase = 1, running = 0.
  - done = 0, pass = 0, timeout = 0, exit_code = 0, cycle_count = 0.
  - Console FIFO empty, console_overflow = 0.
- States: INIT -> HOLD -> RUN -> {DONE | TIMEOUT}.
- INIT: core_reset = 1, init_phase = 1. Leaves to HOLD after INIT_CYCLES clocks.
- HOLD: core_reset = 1, init_phase = 0. Leaves to RUN after RESET_CYCLES clocks.
- Release timing: core_reset falls exactly INIT_CYCLES + RESET_CYCLES edges after the first edge with reset = 0. All outputs are registered.
- RUN:
  - core_reset = 0, running = 1.
  - cycle_count increments by 1 every RUN cycle.
- Tohost decode: a store in RUN with store_valid, store_addr == TOHOST_ADDR and store_strb == 4'hF is decoded on store_data.
  - store_data[0] == 0: ignored.
  - store_data == 1: next state DONE, done = 1, pass = 1.
  - store_data[0] == 1 and store_data != 1: next state DONE, done = 1, pass = 0, exit_code = store_data[31:1].
- Timeout: in RUN, when cycle_count == TIMEOUT_CYCLES - 1 and no terminating store occurs that cycle, next state TIMEOUT, timeout = 1.
- Simultaneous tohost store and timeout in the same cycle: the tohost store wins.
- DONE and TIMEOUT:
  - Absorbing until reset.
  - core_reset = 1 again (core parked), running = 0.
  - cycle_count frozen at its final value (includes the terminating cycle).
  - The console FIFO still drains.
- Stores outside RUN are ignored, including tohost and console stores.
- cycle_count saturates at all-ones and never wraps.
- Reset asserted in any state restarts the full INIT sequence and flushes the FIFO.

Optional Feature:
SIM_SUPERVISOR_CONSOLE_EN
- Defined:
  - A RUN store with store_valid, store_addr == CONSOLE_ADDR and store_strb[0] == 1 pushes store_data[7:0] into a show-ahead FIFO.
  - console_valid = FIFO not empty; the byte is visible on the edge after the push.
  - Pop occurs on console_valid && console_ready.
  - Push when full with no pop: byte dropped, console_overflow set.
  - Push and pop in the same cycle when full: both succeed, no overflow.
- Undefined:
  - console_valid = 0, console_data = 0, console_overflow = 0.
  - Console stores are ignored and no FIFO is instantiated.

Decomposition:
- Package sim_supervisor_pkg:
  - state enum (INIT, HOLD, RUN, DONE, TIMEOUT)
  - TOHOST_PASS = 32'h1
  - console strobe mask
- Sub-module sync_fifo (parametrised WIDTH, DEPTH; show-ahead; full/empty outputs) holds the console buffer. It is instantiated only under the macro.

Test Plan:
- Defaults; release reset at edge 0 -> init_phase high for 10 cycles, core_reset falls at edge 13, running = 1, cycle_count = 0 then increments.
- In RUN, store tohost 32'h1, strb F -> next cycle done = 1, pass = 1, core_reset = 1; cycle_count frozen thereafter.
- Store tohost 32'h0000_0007 -> done = 1, pass = 0, exit_code = 3. Store tohost 32'h2 beforehand -> ignored, still running.
- TIMEOUT_CYCLES = 20, no tohost -> timeout = 1 after 20 RUN cycles, cycle_count = 20. Tohost = 1 on cycle 19 -> done/pass, timeout stays 0.
- Console enabled: 17 byte stores "A".."Q" with console_ready = 0 -> first 16 retained, overflow = 1. Then ready = 1 -> bytes "A".."P" emerge in order.
- Assert reset mid-RUN with FIFO non-empty -> all outputs return to reset values, FIFO empty, full INIT/HOLD sequence repeats.
